div_remainder_ctrl: RTL and testbench
=====================================

Name: div_remainder_ctrl

Overview:
- Sequencing and remainder stage directly downstream of the divisor register in the PA1 sequential divider datapath.
- Owns the 64-bit remainder/quotient shift register and the iteration counter.
- Drives the divisor register's write-control line, then consumes the divisor value it presents.
- Runs a 32-iteration restoring division, one iteration per clock, and reports the result with a start/done handshake.

Parameters:
- WIDTH, 32, operand width; the quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request a division; honoured only in IDLE.
- dividend_in  input  WIDTH  dividend; captured on the edge that accepts start.
- divisor_in  input  WIDTH  divisor value presented by the divisor register; sampled in LOAD.
- w_ctrl_out  output  1  write-control to the divisor register; high only in LOAD.
- busy  output  1  high in LOAD and ITER.
- done  output  1  one-cycle pulse; high only in DONE.
- div_by_zero  output  1  set with the result when the divisor is 0; held until the next accepted start.
- quotient_out  output  WIDTH  registered quotient; held until the next accepted start.
- remainder_out  output  WIDTH  registered remainder; held until the next accepted start.

Behaviour:
- Reset (reset==0 at a rising edge), including mid-operation:
  - State returns to IDLE; counter = 0; internal rem register = 0.
  - All outputs go to 0 on that edge: w_ctrl_out, busy, done, div_by_zero, quotient_out, remainder_out.
  - Reset overrides start.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - start==1: rem <= {WIDTH'b0, dividend_in}; clear div_by_zero, quotient_out, remainder_out; go to LOAD.
  - start==0: stay in IDLE.
- LOAD:
  - w_ctrl_out=1; divisor_in is valid during this cycle and is latched into an internal dvs register.
  - divisor_in==0: quotient_out <= all ones; remainder_out <= rem[WIDTH-1:0] (the dividend); div_by_zero <= 1; go to DONE.
  - Otherwise: counter <= 0; go to ITER.
- ITER, one iteration per edge:
  - partial = rem[2*WIDTH-1:WIDTH-1], a WIDTH+1-bit value.
  - diff = partial - {1'b0, dvs}, a WIDTH+2-bit subtraction; "negative" means the borrow out is set.
  - Non-negative: rem <= {diff[WIDTH-1:0], rem[WIDTH-2:0], 1'b1}.
  - Negative: rem <= {rem[2*WIDTH-2:0], 1'b0}.
  - counter increments each ITER edge.
  - On the edge where counter==WIDTH-1: quotient_out <= new rem low half; remainder_out <= new rem high half; go to DONE.
- DONE:
  - done=1 for exactly one cycle; unconditionally returns to IDLE.
  - start sampled in DONE is ignored.
- Timing:
  - Normal case: done is high in the cycle after the 33rd rising edge following the start-accepting edge (1 LOAD + 32 ITER).
  - Divide-by-zero: done is high in the cycle after the 1st edge following the start-accepting edge.
- Boundary cases:
  - start asserted while busy or in DONE: ignored, no side effects.
  - dividend_in changing after acceptance: no effect.
  - divisor_in changing outside LOAD: no effect.
- Invariant: the rem high half is always < dvs between iterations, so the WIDTH+1-bit partial never overflows.

Optional Feature:
- Macro: DIV_REMAINDER_SIGNED_EN.
- Defined: operands are two's complement.
  - LOAD takes magnitudes of both operands and records q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - On entry to DONE: quotient is negated if q_neg; remainder is negated if r_neg.
  - Divide-by-zero: quotient = all ones, remainder = original dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Adds no cycles; latency is unchanged.
- Not defined: purely unsigned, no sign logic synthesized.

Test Plan:
- 100 / 7: start with dividend_in=100, divisor_in=7 presented while w_ctrl_out=1 -> done high 33 edges later, quotient_out=14, remainder_out=2, div_by_zero=0, busy low in the done cycle.
- 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0. Then 0x12345678 / 0x12345679 -> quotient 0, remainder 0x12345678.
- 5 / 0 -> done 1 edge after LOAD entry, div_by_zero=1, quotient 0xFFFFFFFF, remainder 5. A following 9 / 3 clears div_by_zero and yields quotient 3, remainder 0.
- Start 100 / 7, assert reset=0 for one edge at ITER counter=10 -> next cycle: IDLE, all outputs 0, done never pulses. A following 50 / 8 gives quotient 6, remainder 2.
- Start 100 / 7, pulse start with dividend 999 at ITER counter=5 and again in DONE -> still quotient 14, remainder 2, exactly one done pulse.
- With DIV_REMAINDER_SIGNED_EN: -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.

Source files
------------

// File: rtl/div_remainder_ctrl.sv
// div_remainder_ctrl: 32-iteration restoring divider stage that drives the divisor register write-control.
// Define DIV_REMAINDER_SIGNED_EN for two's complement operands; unsigned otherwise.
module div_remainder_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             w_ctrl_out,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, ITER = 2'd2, DONE = 2'd3;
    logic [1:0]         state;
    logic [2*WIDTH-1:0] rem, rem_nxt;
    logic [WIDTH-1:0]   dvs, sub, dvd_mag, dvs_mag, q_fin, r_fin;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    // Borrow of the WIDTH+1-bit partial minus divisor; the low bits of the difference suffice otherwise.
    assign neg     = rem[2*WIDTH-1:WIDTH-1] < {1'b0, dvs};
    assign sub     = rem[2*WIDTH-2:WIDTH-1] - dvs;
    assign rem_nxt = neg ? {rem[2*WIDTH-2:0], 1'b0} : {sub, rem[WIDTH-2:0], 1'b1};
    assign w_ctrl_out = state == LOAD;
    assign busy       = state == LOAD || state == ITER;
    assign done       = state == DONE;
`ifdef DIV_REMAINDER_SIGNED_EN
    logic q_neg, r_neg;
    assign dvd_mag = rem[WIDTH-1] ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    assign dvs_mag = divisor_in[WIDTH-1] ? -divisor_in : divisor_in;
    assign q_fin   = q_neg ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
    assign r_fin   = r_neg ? -rem_nxt[2*WIDTH-1:WIDTH] : rem_nxt[2*WIDTH-1:WIDTH];
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == LOAD) begin
            q_neg <= rem[WIDTH-1] ^ divisor_in[WIDTH-1];
            r_neg <= rem[WIDTH-1];
        end
    end
`else
    assign dvd_mag = rem[WIDTH-1:0];
    assign dvs_mag = divisor_in;
    assign q_fin   = rem_nxt[WIDTH-1:0];
    assign r_fin   = rem_nxt[2*WIDTH-1:WIDTH];
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            rem           <= '0;
            dvs           <= '0;
            div_by_zero   <= 1'b0;
            quotient_out  <= '0;
            remainder_out <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rem           <= {{WIDTH{1'b0}}, dividend_in};
                    div_by_zero   <= 1'b0;
                    quotient_out  <= '0;
                    remainder_out <= '0;
                    state         <= LOAD;
                end
                LOAD: begin
                    dvs <= dvs_mag;
                    if (divisor_in == '0) begin
                        quotient_out  <= '1;
                        remainder_out <= rem[WIDTH-1:0];
                        div_by_zero   <= 1'b1;
                        state         <= DONE;
                    end else begin
                        rem   <= {{WIDTH{1'b0}}, dvd_mag};
                        cnt   <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        quotient_out  <= q_fin;
                        remainder_out <= r_fin;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_remainder_ctrl.sv
// tb_div_remainder_ctrl: directed vectors with a queued scoreboard checked by a done-driven monitor.
module tb_div_remainder_ctrl;
    logic        clk = 0, reset = 0, start = 0;
    logic [31:0] dividend_in = 0, divisor_in = 0, cur_div = 0;
    logic        w_ctrl_out, busy, done, div_by_zero;
    logic [31:0] quotient_out, remainder_out;
    typedef struct {
        logic [31:0] q, r;
        logic        dbz;
        int          lat;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0, t_start = 0, dones = 0, d0;

    div_remainder_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .dividend_in(dividend_in),
        .divisor_in(divisor_in), .w_ctrl_out(w_ctrl_out), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .quotient_out(quotient_out), .remainder_out(remainder_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // Divisor register model: valid value only while write-control is high, garbage otherwise.
    always @(negedge clk) divisor_in = w_ctrl_out ? cur_div : 32'hDEAD_BEEF;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clk) if (done) begin
        exp_t e;
        dones++;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
            e = sb.pop_front();
            chk("quotient", quotient_out, e.q);
            chk("remainder", remainder_out, e.r);
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            chk("busy_in_done", 32'(busy), 0);
            chk("latency", 32'(cyc - t_start), 32'(e.lat));
        end
    end

    task automatic launch(input logic [31:0] dvd, input logic [31:0] dvs, input logic [31:0] q,
                          input logic [31:0] r, input logic dbz, input bit push);
        exp_t e;
        @(negedge clk);
        e.q = q; e.r = r; e.dbz = dbz; e.lat = dbz ? 1 : 33;
        if (push) sb.push_back(e);
        cur_div = dvs;
        start = 1;
        dividend_in = dvd;
        @(posedge clk);
        @(negedge clk);
        t_start = cyc;
        start = 0;
        dividend_in = 32'h0BAD_F00D;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: got done=0 expected done within 60 cycles");
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] dvd, input logic [31:0] dvs, input logic [31:0] q,
                       input logic [31:0] r, input logic dbz);
        launch(dvd, dvs, q, r, dbz, 1);
        wait_done();
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_w_ctrl"}, 32'(w_ctrl_out), 0);
        chk({n, "_busy"}, 32'(busy), 0);
        chk({n, "_done"}, 32'(done), 0);
        chk({n, "_dbz"}, 32'(div_by_zero), 0);
        chk({n, "_q"}, quotient_out, 0);
        chk({n, "_r"}, remainder_out, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset = 1;
        run(32'd100, 32'd7, 32'd14, 32'd2, 0);
        run(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
        run(32'h1234_5678, 32'h1234_5679, 32'd0, 32'h1234_5678, 0);
        run(32'h3B9A_CA07, 32'h0001_0000, 32'd15258, 32'd51719, 0);
        run(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
        run(32'd9, 32'd3, 32'd3, 32'd0, 0);
        // Abort mid-iteration with reset: no result expected for this run.
        d0 = dones;
        launch(32'd100, 32'd7, 0, 0, 0, 0);
        repeat (11) @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        chk_zero("midreset");
        repeat (40) @(negedge clk);
        chk("midreset_no_done", 32'(dones - d0), 0);
        run(32'd50, 32'd8, 32'd6, 32'd2, 0);
        // Starts while busy and in DONE must be ignored.
        d0 = dones;
        launch(32'd100, 32'd7, 32'd14, 32'd2, 0, 1);
        repeat (6) @(negedge clk);
        start = 1;
        dividend_in = 32'd999;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (40) @(negedge clk);
        chk("ignored_start_one_done", 32'(dones - d0), 1);
        chk("ignored_start_idle", 32'(busy), 0);
`ifdef DIV_REMAINDER_SIGNED_EN
        run(-32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run(32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        run(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
`endif
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
